// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-and-add unsigned multiplier with
// fixed-point rescaling (round-half-up, saturating).
//
// Retires one multiplier bit per clock. An accepted start latches both
// operands; WIDTH cycles later the exact product, the rescaled value and the
// saturation flag update together and done pulses for one cycle. Results are
// held until the next operation completes.
//
// Handshake: start is accepted on a rising edge when the block is in IDLE or
// FINISH. busy is high for exactly WIDTH cycles after the accept edge. done is
// high for the single cycle that follows. start seen while busy is ignored.
//
// Ports:
//   clk          - clock, rising edge
//   reset        - synchronous, active-high; aborts any operation in flight
//   start        - request a new operation
//   Multiplicand - operand A (WIDTH), latched on accept
//   Multiplier   - operand B (WIDTH), latched on accept
//   busy         - operation in progress
//   done         - one-cycle pulse, results valid
//   Product      - exact A*B (2*WIDTH)
//   Scaled       - round(Product / 2^FRAC), saturated to WIDTH bits
//   overflow     - Scaled saturated
//   fsm_state    - current FSM state encoding (debug visibility)

`ifndef SIZE_INT
`define SIZE_INT 16
`endif

module seq_multiplier #(
  parameter int WIDTH = `SIZE_INT,
  parameter int FRAC  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     Multiplicand,
  input  logic [WIDTH-1:0]     Multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   Product,
  output logic [WIDTH-1:0]     Scaled,
  output logic                 overflow,
  output logic [1:0]           fsm_state
);

  localparam int CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int FRAC_M1 = (FRAC > 0) ? FRAC - 1 : 0;
  // Half an output LSB, added before truncation for round-half-up.
  localparam logic [2*WIDTH:0] ROUND =
    (FRAC > 0) ? ((2*WIDTH+1)'(1) << FRAC_M1) : '0;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] mcand;
  // Upper WIDTH+1 bits: partial sum. Lower WIDTH bits: remaining multiplier
  // bits, consumed from the LSB as the register shifts right.
  logic [2*WIDTH:0] acc;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic [WIDTH:0]   add_val;
  logic [WIDTH:0]   upper_sum;
  logic [2*WIDTH:0] acc_step;
  logic [2*WIDTH:0] rounded;
  logic [2*WIDTH:0] r_shift;
  logic             sat;
  logic [WIDTH-1:0] scaled_next;

  assign fsm_state = state;
  assign accept    = start && ((state == IDLE) || (state == FINISH));

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = FINISH;
      FINISH:  state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // One shift-and-add step, and the rescaling of the value it produces. On
  // the final RUN cycle acc_step is the complete product (top bit zero).
  always_comb begin
    add_val     = acc[0] ? {1'b0, mcand} : '0;
    upper_sum   = acc[2*WIDTH:WIDTH] + add_val;
    acc_step    = {upper_sum, acc[WIDTH-1:0]} >> 1;
    rounded     = acc_step + ROUND;
    r_shift     = rounded >> FRAC;
    sat         = |r_shift[2*WIDTH:WIDTH];
    scaled_next = sat ? '1 : r_shift[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand    <= '0;
      acc      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Product  <= '0;
      Scaled   <= '0;
      overflow <= 1'b0;
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == FINISH);
      if (accept) begin
        mcand <= Multiplicand;
        acc   <= {{(WIDTH+1){1'b0}}, Multiplier};
        cnt   <= '0;
      end else if (state == RUN) begin
        acc <= acc_step;
        cnt <= cnt + CW'(1);
        if (cnt == LAST) begin
          Product  <= acc_step[2*WIDTH-1:0];
          Scaled   <= scaled_next;
          overflow <= sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed self-checking bench for seq_multiplier
// (WIDTH=16, FRAC=8). Expected results are hand-computed constants pushed
// into expectation queues; a monitor pops them whenever done pulses.

module tb_seq_multiplier;

  localparam int W = 16;

  logic           clk;
  logic           reset;
  logic           start;
  logic [W-1:0]   Multiplicand;
  logic [W-1:0]   Multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] Product;
  logic [W-1:0]   Scaled;
  logic           overflow;
  logic [1:0]     fsm_state;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   exp_s_q[$];
  logic           exp_o_q[$];

  seq_multiplier #(.WIDTH(W), .FRAC(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .busy         (busy),
    .done         (done),
    .Product      (Product),
    .Scaled       (Scaled),
    .overflow     (overflow),
    .fsm_state    (fsm_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("product", Product, exp_q.pop_front());
        check("scaled", {16'd0, Scaled}, {16'd0, exp_s_q.pop_front()});
        check("overflow", {31'd0, overflow}, {31'd0, exp_o_q.pop_front()});
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic expect_result(input logic [31:0] p, input logic [15:0] s, input logic o);
    exp_q.push_back(p);
    exp_s_q.push_back(s);
    exp_o_q.push_back(o);
  endtask

  // Drive a start for one cycle, scramble operands after acceptance, then
  // measure latency (edges from accept edge to done) and busy length.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] p, input logic [15:0] s, input logic o);
    int lat;
    int bc;
    expect_result(p, s, o);
    start = 1'b1;
    Multiplicand = a;
    Multiplier = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    Multiplicand = 16'($urandom_range(0, 65535));
    Multiplier = 16'($urandom_range(0, 65535));
    lat = 1;
    bc = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      lat++;
      @(negedge clk);
    end
    check("latency", lat, 32'd17);
    check("busy_cycles", bc, 32'd16);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!done) check(tag, 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen_before;
    reset = 1'b1;
    start = 1'b0;
    Multiplicand = '0;
    Multiplier = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_product", Product, 32'd0);
    check("rst_scaled", {16'd0, Scaled}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_state", {30'd0, fsm_state}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors: A, B, Product, Scaled, overflow
    run_op(16'd100, 16'd3, 32'd300, 16'd1, 1'b0);
    run_op(16'd200, 16'd7, 32'd1400, 16'd5, 1'b0);
    run_op(16'd128, 16'd3, 32'd384, 16'd2, 1'b0);
    run_op(16'd383, 16'd1, 32'd383, 16'd1, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16'hFFFF, 1'b1);
    run_op(16'd0, 16'h1234, 32'd0, 16'd0, 1'b0);
    // Results hold through IDLE
    repeat (3) @(negedge clk);
    check("hold_product", Product, 32'd0);
    check("hold_busy", {31'd0, busy}, 32'd0);
    run_op(16'd255, 16'd1, 32'd255, 16'd1, 1'b0);
    repeat (2) @(negedge clk);
    check("hold_scaled", {16'd0, Scaled}, 32'd1);

    // start re-pulsed mid-RUN is ignored; start in FINISH is accepted
    expect_result(32'd25, 16'd0, 1'b0);
    expect_result(32'd81, 16'd0, 1'b0);
    start = 1'b1;
    Multiplicand = 16'd5;
    Multiplier = 16'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    Multiplicand = 16'd9;
    Multiplier = 16'd9;
    @(negedge clk);
    start = 1'b0;
    check("ignored_start_busy", {31'd0, busy}, 32'd1);
    wait_done("timeout_25");
    start = 1'b1;
    Multiplicand = 16'd9;
    Multiplier = 16'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_done", {31'd0, done}, 32'd0);
    wait_done("timeout_81");
    @(negedge clk);

    // Reset mid-RUN aborts with no done
    seen_before = done_seen;
    start = 1'b1;
    Multiplicand = 16'd1000;
    Multiplier = 16'd1000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_product", Product, 32'd0);
    check("abort_scaled", {16'd0, Scaled}, 32'd0);
    check("abort_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    check("abort_no_done", done_seen, seen_before);
    run_op(16'd2, 16'd3, 32'd6, 16'd0, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
